// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode/funct constants, the bubble word,
// the fetch-state encoding and the rt-source helper used by IF and ID.
package pipeline_pkg;

   localparam logic [5:0] OP_R_TYPE = 6'b000000;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] FUNCT_JR  = 6'b001000;

   // sll $0,$0,0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,   // request on the bus this cycle
      WAIT  = 2'd1,   // request outstanding, response wanted
      HOLD  = 2'd2,   // response parked in the skid buffer
      DROP  = 2'd3    // request outstanding, response to be thrown away
   } fetch_state_t;

   // rt is only read as a source by R-type, beq, bne and sw.
   function automatic logic rt_not_source(input logic [5:0] op);
      logic result;
      case (op)
         OP_R_TYPE, OP_BEQ, OP_BNE, OP_SW: result = 1'b0;
         default:                          result = 1'b1;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/fetch_stage_checker.sv
// Protocol checks on the instruction-memory interface of the fetch stage.
module fetch_stage_checker
   import pipeline_pkg::*;
(
   input logic         clk,
   input logic         rst_n,
   input fetch_state_t state,
   input logic         imem_rvalid
);

   // A response is only legal while a request is outstanding (WAIT or DROP).
   a_rvalid_outstanding: assert property (
      @(posedge clk) disable iff (!rst_n)
         !(imem_rvalid && ((state == ISSUE) || (state == HOLD)))
   );

endmodule

// File: rtl/if_id_decode.sv
// Field split of the IF/ID instruction, shared by hazard detection and decode.
module if_id_decode
   import pipeline_pkg::*;
(
   input  logic [31:0] instr,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic        invalid_rt
);

   // Pure bit slicing plus the rt-source classification.
   always_comb begin
      op         = instr[31:26];
      funct      = instr[5:0];
      rs         = instr[25:21];
      rt         = instr[20:16];
      invalid_rt = rt_not_source(instr[31:26]);
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, single-outstanding fetch FSM with a one-entry skid
// buffer, and the IF/ID pipeline register.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PC_Stall,
   input  logic        IF_ID_Stall,
   input  logic        IF_ID_Flush,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        IF_ID_Valid,
   output logic [31:0] IF_ID_Instr,
   output logic [31:0] IF_ID_PC4,
   output logic [5:0]  IF_ID_OP,
   output logic [5:0]  IF_ID_Funct,
   output logic [4:0]  IF_ID_RS,
   output logic [4:0]  IF_ID_RT,
   output logic        IF_ID_invalidRt
);

   fetch_state_t state;
   fetch_state_t state_nxt;
   logic [31:0]  pc;
   logic [31:0]  pc_nxt;
   logic [31:0]  skid;
   logic [31:0]  skid_nxt;
   logic         valid_nxt;
   logic [31:0]  instr_nxt;
   logic [31:0]  pc4_nxt;
   logic [31:0]  pc_plus4;
   logic [31:0]  redirect_aligned;
   logic         stall;

   assign stall            = PC_Stall | IF_ID_Stall;
   assign pc_plus4         = pc + 32'd4;
   assign redirect_aligned = {redirect_pc[31:2], 2'b00};
   assign imem_req         = (state == ISSUE) & rst_n;
   assign imem_addr        = pc;

   // Next state, PC, skid and IF/ID contents; flush takes priority over stall.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      skid_nxt  = skid;
      valid_nxt = IF_ID_Valid;
      instr_nxt = IF_ID_Instr;
      pc4_nxt   = IF_ID_PC4;
      if (IF_ID_Flush) begin
         pc_nxt    = redirect_aligned;
         valid_nxt = 1'b0;
         instr_nxt = NOP_INSTR;
         pc4_nxt   = 32'd0;
         case (state)
            ISSUE:   state_nxt = DROP;
            // A same-cycle response retires the outstanding request, so
            // there is nothing left to drop.
            WAIT:    state_nxt = imem_rvalid ? ISSUE : DROP;
            HOLD:    state_nxt = ISSUE;
            DROP:    state_nxt = imem_rvalid ? ISSUE : DROP;
            default: state_nxt = ISSUE;
         endcase
      end else begin
         case (state)
            ISSUE: begin
               state_nxt = WAIT;
               if (!stall) begin
                  valid_nxt = 1'b0;
                  instr_nxt = NOP_INSTR;
                  pc4_nxt   = 32'd0;
               end else begin
                  valid_nxt = IF_ID_Valid;
               end
            end
            WAIT: begin
               if (imem_rvalid && !stall) begin
                  valid_nxt = 1'b1;
                  instr_nxt = imem_rdata;
                  pc4_nxt   = pc_plus4;
                  pc_nxt    = pc_plus4;
                  state_nxt = ISSUE;
               end else if (imem_rvalid) begin
                  skid_nxt  = imem_rdata;
                  state_nxt = HOLD;
               end else if (!stall) begin
                  valid_nxt = 1'b0;
                  instr_nxt = NOP_INSTR;
                  pc4_nxt   = 32'd0;
               end else begin
                  state_nxt = WAIT;
               end
            end
            HOLD: begin
               if (!stall) begin
                  valid_nxt = 1'b1;
                  instr_nxt = skid;
                  pc4_nxt   = pc_plus4;
                  pc_nxt    = pc_plus4;
                  state_nxt = ISSUE;
               end else begin
                  state_nxt = HOLD;
               end
            end
            DROP: begin
               if (imem_rvalid) begin
                  state_nxt = ISSUE;
               end else begin
                  state_nxt = DROP;
               end
               if (!stall) begin
                  valid_nxt = 1'b0;
                  instr_nxt = NOP_INSTR;
                  pc4_nxt   = 32'd0;
               end else begin
                  valid_nxt = IF_ID_Valid;
               end
            end
            default: state_nxt = ISSUE;
         endcase
      end
   end

   // State, PC, skid buffer and IF/ID register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ISSUE;
         pc          <= RESET_PC;
         skid        <= 32'd0;
         IF_ID_Valid <= 1'b0;
         IF_ID_Instr <= NOP_INSTR;
         IF_ID_PC4   <= 32'd0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         skid        <= skid_nxt;
         IF_ID_Valid <= valid_nxt;
         IF_ID_Instr <= instr_nxt;
         IF_ID_PC4   <= pc4_nxt;
      end
   end

   if_id_decode u_decode (
      .instr      (IF_ID_Instr),
      .op         (IF_ID_OP),
      .funct      (IF_ID_Funct),
      .rs         (IF_ID_RS),
      .rt         (IF_ID_RT),
      .invalid_rt (IF_ID_invalidRt)
   );

   fetch_stage_checker u_checker (
      .clk         (clk),
      .rst_n       (rst_n),
      .state       (state),
      .imem_rvalid (imem_rvalid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/flush/latency
// traffic checked against a flag-based behavioural model of the fetch stage.
module tb_fetch_stage;
   import pipeline_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, PC_Stall, IF_ID_Stall, IF_ID_Flush;
   logic [31:0] redirect_pc;
   logic        imem_req, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        IF_ID_Valid, IF_ID_invalidRt;
   logic [31:0] IF_ID_Instr, IF_ID_PC4;
   logic [5:0]  IF_ID_OP, IF_ID_Funct;
   logic [4:0]  IF_ID_RS, IF_ID_RT;

   int checks = 0;
   int errors = 0;

   // reference model: what the stage should hold after each edge
   logic [31:0] m_pc, m_skid, m_instr, m_pc4;
   bit          m_v, m_out, m_discard, m_held;
   // memory model: one pending response
   bit          pend_v;
   int          pend_cnt;
   logic [31:0] pend_data;
   int          lat;
   bit          lat_rand, use_fixed;
   logic [31:0] fixed_word;

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall),
      .IF_ID_Flush(IF_ID_Flush), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .IF_ID_Valid(IF_ID_Valid), .IF_ID_Instr(IF_ID_Instr),
      .IF_ID_PC4(IF_ID_PC4), .IF_ID_OP(IF_ID_OP), .IF_ID_Funct(IF_ID_Funct),
      .IF_ID_RS(IF_ID_RS), .IF_ID_RT(IF_ID_RT), .IF_ID_invalidRt(IF_ID_invalidRt)
   );

   function automatic bit exp_inv(input logic [5:0] op);
      return !(op == 6'b000000 || op == 6'b000100 || op == 6'b000101 || op == 6'b101011);
   endfunction

   function automatic bit m_issuing();
      return !m_out && !m_held;
   endfunction

   function automatic void model_reset();
      m_pc = 32'h0; m_skid = 32'h0; m_instr = NOP_INSTR; m_pc4 = 32'h0;
      m_v = 1'b0; m_out = 1'b0; m_discard = 1'b0; m_held = 1'b0;
      pend_v = 1'b0; pend_cnt = 0;
   endfunction

   function automatic void model_bubble(input bit stall);
      if (!stall) begin
         m_v = 1'b0; m_instr = NOP_INSTR; m_pc4 = 32'h0;
      end
   endfunction

   function automatic void model_load(input logic [31:0] w);
      m_v = 1'b1; m_instr = w; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
   endfunction

   // one clock edge of the intended behaviour
   function automatic void model_edge(input bit stall, input bit flush, input bit rv,
                                      input logic [31:0] rd, input logic [31:0] red);
      bit issuing = m_issuing();
      if (flush) begin
         m_v = 1'b0; m_instr = NOP_INSTR; m_pc4 = 32'h0; m_held = 1'b0;
         if (issuing) begin m_out = 1'b1; m_discard = 1'b1; end
         else if (m_out && rv) begin m_out = 1'b0; m_discard = 1'b0; end
         else if (m_out) m_discard = 1'b1;
         m_pc = {red[31:2], 2'b00};
      end else if (issuing) begin
         m_out = 1'b1; m_discard = 1'b0; model_bubble(stall);
      end else if (m_held) begin
         if (!stall) begin model_load(m_skid); m_held = 1'b0; end
      end else if (m_discard) begin
         if (rv) begin m_out = 1'b0; m_discard = 1'b0; end
         model_bubble(stall);
      end else begin
         if (rv && !stall) begin model_load(rd); m_out = 1'b0; end
         else if (rv) begin m_skid = rd; m_held = 1'b1; m_out = 1'b0; end
         else model_bubble(stall);
      end
   endfunction

   // drive memory for this cycle, advance the model, take one clock edge
   task automatic drive_cycle();
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend_v) begin
         if (pend_cnt == 0) begin
            imem_rvalid = 1'b1; imem_rdata = pend_data; pend_v = 1'b0;
         end else pend_cnt--;
      end
      if (m_issuing()) begin
         pend_v    = 1'b1;
         pend_cnt  = (lat_rand ? $urandom_range(1, 4) : lat) - 1;
         pend_data = use_fixed ? fixed_word : $urandom;
      end
      model_edge(PC_Stall | IF_ID_Stall, IF_ID_Flush, imem_rvalid, imem_rdata, redirect_pc);
      @(posedge clk);
      #1;
   endtask

   task automatic go_issue();
      int n = 0;
      PC_Stall = 1'b0; IF_ID_Stall = 1'b0; IF_ID_Flush = 1'b0;
      while (!m_issuing() && n < 20) begin drive_cycle(); n++; end
      checks++;
      if (imem_req !== 1'b1) begin
         errors++; $display("FAIL go_issue got req=%b exp 1 after %0d cycles", imem_req, n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; PC_Stall = 1'b0; IF_ID_Stall = 1'b0; IF_ID_Flush = 1'b0;
      redirect_pc = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      rst_n = 1'b1;
      #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         errors++; $display("FAIL reset_release got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
      end
      checks++;
      if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PC4} !== {1'b0, NOP_INSTR, 32'h0}) begin
         errors++; $display("FAIL reset_ifid got v=%b i=%h p=%h exp 0/nop/0", IF_ID_Valid, IF_ID_Instr, IF_ID_PC4);
      end
   endtask

   task automatic test_first_fetch();
      lat_rand = 1'b0; lat = 1; use_fixed = 1'b1; fixed_word = 32'h2008_0005;
      drive_cycle();
      checks++;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL ff_cycle1_req got=%b exp=0", imem_req); end
      drive_cycle();
      checks++;
      if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PC4} !== {1'b1, 32'h2008_0005, 32'h4}) begin
         errors++; $display("FAIL ff_ifid got v=%b i=%h p=%h exp 1/20080005/4", IF_ID_Valid, IF_ID_Instr, IF_ID_PC4);
      end
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin
         errors++; $display("FAIL ff_next_req got req=%b addr=%h exp 1/4", imem_req, imem_addr);
      end
   endtask

   task automatic test_stall();
      logic [31:0] base_pc, word;
      logic [64:0] held;
      lat_rand = 1'b0; lat = 1; use_fixed = 1'b0;
      go_issue();
      base_pc = imem_addr;
      drive_cycle();
      word = pend_data;
      held = {m_v, m_instr, m_pc4};
      PC_Stall = 1'b1; IF_ID_Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_cycle();
         checks++;
         if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PC4} !== held) begin
            errors++; $display("FAIL stall_hold i=%0d got v=%b i=%h p=%h exp %h", i, IF_ID_Valid, IF_ID_Instr, IF_ID_PC4, held);
         end
      end
      checks++;
      if (dut.state !== HOLD) begin errors++; $display("FAIL stall_state got=%0d exp=%0d", dut.state, HOLD); end
      PC_Stall = 1'b0; IF_ID_Stall = 1'b0;
      drive_cycle();
      checks++;
      if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PC4} !== {1'b1, word, base_pc + 32'd4}) begin
         errors++; $display("FAIL stall_release got v=%b i=%h p=%h exp 1/%h/%h", IF_ID_Valid, IF_ID_Instr, IF_ID_PC4, word, base_pc + 32'd4);
      end
      drive_cycle();
      drive_cycle();
      checks++;
      if ({IF_ID_Valid, IF_ID_PC4} !== {1'b1, base_pc + 32'd8}) begin
         errors++; $display("FAIL stall_next got v=%b p=%h exp 1/%h", IF_ID_Valid, IF_ID_PC4, base_pc + 32'd8);
      end
   endtask

   task automatic test_flush_wait();
      lat_rand = 1'b0; lat = 3; use_fixed = 1'b0;
      go_issue();
      drive_cycle();
      IF_ID_Flush = 1'b1; redirect_pc = 32'h40;
      drive_cycle();
      IF_ID_Flush = 1'b0;
      checks++;
      if ({IF_ID_Valid, imem_req} !== 2'b00) begin
         errors++; $display("FAIL fw_bubble got v=%b req=%b exp 0/0", IF_ID_Valid, imem_req);
      end
      drive_cycle();
      drive_cycle();
      checks++;
      if ({IF_ID_Valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h40}) begin
         errors++; $display("FAIL fw_redirect got v=%b req=%b addr=%h exp 0/1/40", IF_ID_Valid, imem_req, imem_addr);
      end
      lat = 1;
      drive_cycle();
      drive_cycle();
      checks++;
      if ({IF_ID_Valid, IF_ID_PC4} !== {1'b1, 32'h44}) begin
         errors++; $display("FAIL fw_first got v=%b p=%h exp 1/44", IF_ID_Valid, IF_ID_PC4);
      end
   endtask

   task automatic test_flush_hold();
      lat_rand = 1'b0; lat = 1; use_fixed = 1'b0;
      go_issue();
      drive_cycle();
      PC_Stall = 1'b1; IF_ID_Stall = 1'b1;
      drive_cycle();
      IF_ID_Flush = 1'b1; redirect_pc = 32'h100;
      drive_cycle();
      PC_Stall = 1'b0; IF_ID_Stall = 1'b0; IF_ID_Flush = 1'b0;
      checks++;
      if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PC4} !== {1'b0, NOP_INSTR, 32'h0}) begin
         errors++; $display("FAIL fh_bubble got v=%b i=%h p=%h exp 0/nop/0", IF_ID_Valid, IF_ID_Instr, IF_ID_PC4);
      end
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
         errors++; $display("FAIL fh_redirect got req=%b addr=%h exp 1/100", imem_req, imem_addr);
      end
   endtask

   task automatic test_decode_wrap();
      lat_rand = 1'b0; lat = 1; use_fixed = 1'b1;
      fixed_word = 32'h8C09_0004;
      go_issue(); drive_cycle(); drive_cycle();
      checks++;
      if ({IF_ID_OP, IF_ID_RT, IF_ID_invalidRt} !== {6'b100011, 5'd9, 1'b1}) begin
         errors++; $display("FAIL dec_lw got op=%b rt=%0d inv=%b exp 100011/9/1", IF_ID_OP, IF_ID_RT, IF_ID_invalidRt);
      end
      fixed_word = 32'h1109_0003;
      go_issue(); drive_cycle(); drive_cycle();
      checks++;
      if ({IF_ID_OP, IF_ID_RS, IF_ID_RT, IF_ID_Funct, IF_ID_invalidRt} !== {6'b000100, 5'd8, 5'd9, 6'd3, 1'b0}) begin
         errors++; $display("FAIL dec_beq got op=%b rs=%0d rt=%0d fn=%0d inv=%b exp 000100/8/9/3/0", IF_ID_OP, IF_ID_RS, IF_ID_RT, IF_ID_Funct, IF_ID_invalidRt);
      end
      go_issue();
      IF_ID_Flush = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      drive_cycle();
      go_issue();
      checks++;
      if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
      drive_cycle(); drive_cycle();
      checks++;
      if ({IF_ID_Valid, IF_ID_PC4, imem_addr} !== {1'b1, 32'h0, 32'h0}) begin
         errors++; $display("FAIL wrap_pc4 got v=%b p=%h addr=%h exp 1/0/0", IF_ID_Valid, IF_ID_PC4, imem_addr);
      end
   endtask

   task automatic test_random();
      logic [22:0] exp_f;
      lat_rand = 1'b1; use_fixed = 1'b0;
      for (int c = 0; c < 400; c++) begin
         PC_Stall    = ($urandom_range(0, 99) < 15);
         IF_ID_Stall = ($urandom_range(0, 99) < 10);
         IF_ID_Flush = ($urandom_range(0, 99) < 8);
         redirect_pc = $urandom;
         drive_cycle();
         exp_f = {m_instr[31:26], m_instr[5:0], m_instr[25:21], m_instr[20:16], exp_inv(m_instr[31:26])};
         checks++;
         if ({imem_req, imem_addr} !== {m_issuing(), m_pc}) begin
            errors++; $display("FAIL rnd_req c=%0d got %b/%h exp %b/%h", c, imem_req, imem_addr, m_issuing(), m_pc);
         end
         checks++;
         if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PC4} !== {m_v, m_instr, m_pc4}) begin
            errors++; $display("FAIL rnd_ifid c=%0d got %b/%h/%h exp %b/%h/%h", c, IF_ID_Valid, IF_ID_Instr, IF_ID_PC4, m_v, m_instr, m_pc4);
         end
         checks++;
         if ({IF_ID_OP, IF_ID_Funct, IF_ID_RS, IF_ID_RT, IF_ID_invalidRt} !== exp_f) begin
            errors++; $display("FAIL rnd_fields c=%0d got %h exp %h", c, {IF_ID_OP, IF_ID_Funct, IF_ID_RS, IF_ID_RT, IF_ID_invalidRt}, exp_f);
         end
      end
      PC_Stall = 1'b0; IF_ID_Stall = 1'b0; IF_ID_Flush = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      lat_rand = 1'b0; lat = 3; use_fixed = 1'b1; fixed_word = 32'h2008_0005;
      go_issue();
      drive_cycle();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({imem_req, imem_addr, IF_ID_Valid, IF_ID_Instr, IF_ID_PC4} !== {1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0}) begin
         errors++; $display("FAIL rw_async got req=%b addr=%h v=%b i=%h p=%h exp all reset", imem_req, imem_addr, IF_ID_Valid, IF_ID_Instr, IF_ID_PC4);
      end
      model_reset();
      @(posedge clk); #1;
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++;
      if ({imem_req, imem_addr, IF_ID_Valid} !== {1'b1, 32'h0, 1'b0}) begin
         errors++; $display("FAIL rw_restart got req=%b addr=%h v=%b exp 1/0/0", imem_req, imem_addr, IF_ID_Valid);
      end
      lat = 1;
      drive_cycle(); drive_cycle();
      checks++;
      if ({IF_ID_Valid, IF_ID_Instr, IF_ID_PC4} !== {1'b1, 32'h2008_0005, 32'h4}) begin
         errors++; $display("FAIL rw_fetch got v=%b i=%h p=%h exp 1/20080005/4", IF_ID_Valid, IF_ID_Instr, IF_ID_PC4);
      end
   endtask

   initial begin
      lat = 1; lat_rand = 1'b0; use_fixed = 1'b0; fixed_word = 32'h0;
      test_reset();
      test_first_fetch();
      test_stall();
      test_flush_wait();
      test_flush_hold();
      test_decode_wrap();
      test_random();
      test_reset_in_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
